shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter for the ALU datapath. It supports logical left, logical right, arithmetic right, rotate-left and rotate-right on a WIDTH-bit operand. A valid/ready handshake lets it stall against the ALU result bus without losing or reordering operations. It replaces the fixed 32-bit combinational left shifter, keeping the same shift-by-binary-stage structure (1, 2, 4, … bits), with optional registers between stages.

---
 rtl/shift_pipe.sv | 152 +++++++++++++++
 tb/tb_shift_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR on a WIDTH-bit operand, one binary stage
// per amount bit, with a valid/ready handshake that can stall against the result bus.
module shift_pipe #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 1,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    // One binary stage shifting by s; s is always a power of two below WIDTH, so WIDTH-s > 0.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             sign,
        input int               s
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = d << s;
            OP_SRL:  r = d >> s;
            OP_SRA:  r = (d >> s) | ({WIDTH{sign}} << (WIDTH - s));
            OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
            OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
            default: r = d;
        endcase
        return r;
    endfunction

    if (PIPE != 0) begin : g_pipe
        logic [SHW-1:0]   vq;
        logic [WIDTH-1:0] dq [SHW];
        logic [2:0]       oq [SHW-1];
        logic [SHW-1:0]   aq [SHW-1];
        logic             sq [SHW-1];
        logic             zq;
        logic [SHW-1:0]   rdy;
        logic [WIDTH-1:0] nd [SHW];

        // A slot may load when it is empty or its downstream neighbour can take its content,
        // so bubbles collapse behind a stalled head.
        always_comb begin
            logic r;
            rdy = '0;
            r   = out_ready;
            for (int k = SHW - 1; k >= 0; k--) begin
                r      = !vq[k] || r;
                rdy[k] = r;
            end
        end

        // The remaining amount bits are pre-shifted, so every stage consults bit 0 only.
        always_comb begin
            nd[0] = in_amt[0] ? shift_stage(in_a, in_op, in_a[WIDTH-1], 1) : in_a;
            for (int k = 1; k < SHW; k++) begin
                nd[k] = aq[k-1][0] ? shift_stage(dq[k-1], oq[k-1], sq[k-1], 1 << k) : dq[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vq <= '0;
                zq <= 1'b0;
                for (int k = 0; k < SHW; k++) begin
                    dq[k] <= '0;
                end
                for (int k = 0; k < SHW - 1; k++) begin
                    oq[k] <= '0;
                    aq[k] <= '0;
                    sq[k] <= 1'b0;
                end
            end else begin
                if (rdy[0]) begin
                    vq[0] <= in_valid;
                    dq[0] <= nd[0];
                    oq[0] <= in_op;
                    aq[0] <= in_amt >> 1;
                    sq[0] <= in_a[WIDTH-1];
                end
                for (int k = 1; k < SHW; k++) begin
                    if (rdy[k]) begin
                        vq[k] <= vq[k-1];
                        dq[k] <= nd[k];
                    end
                end
                for (int k = 1; k < SHW - 1; k++) begin
                    if (rdy[k]) begin
                        oq[k] <= oq[k-1];
                        aq[k] <= aq[k-1] >> 1;
                        sq[k] <= sq[k-1];
                    end
                end
                if (rdy[SHW-1]) begin
                    zq <= (nd[SHW-1] == '0);
                end
            end
        end

        assign in_ready  = rdy[0];
        assign out_valid = vq[SHW-1];
        assign out_data  = dq[SHW-1];
        assign out_zero  = zq;
    end else begin : g_flat
        logic             vq;
        logic [WIDTH-1:0] dq;
        logic             zq;
        logic [WIDTH-1:0] res;

        always_comb begin
            res = in_a;
            for (int k = 0; k < SHW; k++) begin
                if (in_amt[k]) begin
                    res = shift_stage(res, in_op, in_a[WIDTH-1], 1 << k);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vq <= 1'b0;
                dq <= '0;
                zq <= 1'b0;
            end else if (in_ready) begin
                vq <= in_valid;
                dq <= res;
                zq <= (res == '0);
            end
        end

        assign in_ready  = !vq || out_ready;
        assign out_valid = vq;
        assign out_data  = dq;
        assign out_zero  = zq;
    end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: a 32-bit pipelined instance and an 8-bit flat instance,
// driven from a shared stimulus bus selected by use8.
module tb_shift_pipe;

    localparam logic [2:0] SLL = 3'b000;
    localparam logic [2:0] SRL = 3'b001;
    localparam logic [2:0] SRA = 3'b010;
    localparam logic [2:0] ROL = 3'b011;
    localparam logic [2:0] ROR = 3'b100;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [4:0]  amt;
        logic [31:0] expData;
        logic        expZero;
        bit          w8;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0;
    logic [4:0]  in_amt = '0;
    logic [2:0]  in_op = '0;
    logic        out_ready = 1'b1;
    bit          use8 = 1'b0;

    logic        in_ready32, out_valid32, out_zero32;
    logic [31:0] out_data32;
    logic        in_ready8, out_valid8, out_zero8;
    logic [7:0]  out_data8;

    logic        rdy, ov, oz;
    logic [31:0] od;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(32), .PIPE(1)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && !use8), .in_ready(in_ready32),
        .in_a(in_a), .in_amt(in_amt), .in_op(in_op),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_data(out_data32), .out_zero(out_zero32)
    );

    shift_pipe #(.WIDTH(8), .PIPE(0)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && use8), .in_ready(in_ready8),
        .in_a(in_a[7:0]), .in_amt(in_amt[2:0]), .in_op(in_op),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .out_zero(out_zero8)
    );

    assign rdy = use8 ? in_ready8 : in_ready32;
    assign ov  = use8 ? out_valid8 : out_valid32;
    assign oz  = use8 ? out_zero8 : out_zero32;
    assign od  = use8 ? {24'h0, out_data8} : out_data32;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void addVec(input logic [2:0] op, input logic [31:0] a, input logic [4:0] amt,
                                   input logic [31:0] expData, input logic expZero, input bit w8);
        vec_t v;
        v.op = op; v.a = a; v.amt = amt; v.expData = expData; v.expZero = expZero; v.w8 = w8;
        vecs.push_back(v);
    endfunction

    // Presents one op and returns at the falling edge right after it was accepted.
    task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                                 input logic [4:0] amt);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_amt = amt;
        #1;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput({name, " accept"}, rdy, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic runVector(input int idx, input vec_t v);
        int lat;
        string name;
        name = $sformatf("vec%0d", idx);
        use8 = v.w8;
        applyStimulus(name, v.op, v.a, v.amt);
        lat = 1;
        while (!ov && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({name, " latency"}, lat, v.w8 ? 1 : 5);
        checkOutput({name, " data"}, od, v.expData);
        checkOutput({name, " zero"}, oz, v.expZero);
    endtask

    task automatic backpressureTest();
        logic [31:0] expQ[$];
        logic [31:0] heldD;
        logic        heldV;
        int sent, got;
        sent = 0;
        got = 0;
        heldV = 1'b0;
        heldD = '0;
        use8 = 1'b0;
        for (int c = 0; c < 80 && got < 10; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 12);
            in_valid = (sent < 10);
            in_op = SLL;
            in_amt = 5'd1;
            in_a = sent + 1;
            #1;
            if (heldV) begin
                checkOutput($sformatf("bp hold valid c%0d", c), ov, 1'b1);
                checkOutput($sformatf("bp hold data c%0d", c), od, heldD);
            end
            checkOutput($sformatf("bp in_ready c%0d", c), rdy, ((sent - got) < 5 || out_ready) ? 1 : 0);
            if (ov && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput($sformatf("bp spurious c%0d", c), od, 32'hFFFF_FFFF);
                end else begin
                    checkOutput($sformatf("bp order c%0d", c), od, expQ.pop_front());
                end
                got++;
            end
            if (in_valid && rdy) begin
                expQ.push_back((sent + 1) * 2);
                sent++;
            end
            heldV = ov && !out_ready;
            heldD = od;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        checkOutput("bp results", got, 10);
        checkOutput("bp accepted", sent, 10);
    endtask

    task automatic resetMidOpTest();
        int n;
        use8 = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op = SLL;
            in_amt = 5'd1;
            in_a = i + 5;
            #1;
            checkOutput($sformatf("rst accept %0d", i), rdy, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst mid valid", ov, 1'b0);
        checkOutput("rst mid data", od, 32'h0);
        rst = 1'b0;
        in_valid = 1'b1;
        in_op = SLL;
        in_amt = 5'd2;
        in_a = 32'h3;
        #1;
        checkOutput("rst ready after", rdy, 1'b1);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (ov) begin
                checkOutput($sformatf("rst post data c%0d", c), od, 32'h0000_000C);
                n++;
            end
        end
        checkOutput("rst post count", n, 1);
    endtask

    task automatic throughput8Test();
        use8 = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = (c < 8);
            in_op = SLL;
            in_amt = 5'd1;
            in_a = c + 1;
            #1;
            if (c < 8) begin
                checkOutput($sformatf("w8 ready c%0d", c), rdy, 1'b1);
            end
            if (c >= 1 && c <= 8) begin
                checkOutput($sformatf("w8 valid c%0d", c), ov, 1'b1);
                checkOutput($sformatf("w8 data c%0d", c), od, 2 * c);
            end else begin
                checkOutput($sformatf("w8 idle c%0d", c), ov, 1'b0);
            end
        end
        in_valid = 1'b0;
        use8 = 1'b0;
    endtask

    initial begin
        addVec(SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
        for (int op = 0; op < 8; op++) begin
            addVec(3'(op), 32'hA5A5_A5A5, 5'd0, 32'hA5A5_A5A5, 1'b0, 1'b0);
        end
        addVec(SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0);
        addVec(SRL, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0);
        addVec(SRL, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1, 1'b0);
        addVec(SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
        addVec(SRA, 32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF, 1'b0, 1'b0);
        addVec(ROR, 32'h0000_00F1, 5'd4,  32'h1000_000F, 1'b0, 1'b0);
        addVec(ROL, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, 1'b0);
        addVec(ROL, 32'h1234_5678, 5'd31, 32'h091A_2B3C, 1'b0, 1'b0);
        addVec(ROR, 32'h1234_5678, 5'd1,  32'h091A_2B3C, 1'b0, 1'b0);
        addVec(SLL, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, 1'b0, 1'b0);
        addVec(3'b101, 32'hDEAD_BEEF, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b0);
        addVec(SRA, 32'h0000_0090, 5'd3,  32'h0000_00F2, 1'b0, 1'b1);
        addVec(ROL, 32'h0000_0081, 5'd1,  32'h0000_0003, 1'b0, 1'b1);
        addVec(SRL, 32'h0000_0080, 5'd7,  32'h0000_0001, 1'b0, 1'b1);
        addVec(SLL, 32'h0000_0001, 5'd7,  32'h0000_0080, 1'b0, 1'b1);
        addVec(ROR, 32'h0000_0001, 5'd3,  32'h0000_0020, 1'b0, 1'b1);
        addVec(SLL, 32'h0000_0010, 5'd4,  32'h0000_0000, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        checkOutput("reset out_valid", ov, 1'b0);
        checkOutput("reset out_data", od, 32'h0);
        checkOutput("reset out_zero", oz, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset in_ready", rdy, 1'b1);
        use8 = 1'b1;
        #1;
        checkOutput("reset8 out_valid", ov, 1'b0);
        checkOutput("reset8 in_ready", rdy, 1'b1);
        use8 = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            runVector(i, vecs[i]);
        end

        backpressureTest();
        resetMidOpTest();
        throughput8Test();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
